// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control unit.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_ADDIEX = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11,
    ST_HALT   = 4'd12
  } state_t;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_LW    = 3'b001;
  localparam logic [2:0] OP_SW    = 3'b010;
  localparam logic [2:0] OP_BEQ   = 3'b011;
  localparam logic [2:0] OP_ADDI  = 3'b100;
  localparam logic [2:0] OP_J     = 3'b101;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_AND = 4'b0010;
  localparam logic [3:0] FN_OR  = 4'b0011;
  localparam logic [3:0] FN_SLT = 4'b0100;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUB_REGB = 2'b00;
  localparam logic [1:0] ALUB_ONE  = 2'b01;
  localparam logic [1:0] ALUB_SEXT = 2'b10;
  localparam logic [1:0] ALUB_BOFF = 2'b11;

endpackage

// File: rtl/mc_aludec.sv
// R-type function decoder: funct -> ALU operation, flags unsupported functs.
module mc_aludec
  import mc_pkg::*;
#(
  parameter int FNW = 4
) (
  input  logic [FNW-1:0] funct,
  output logic [2:0]     alucontrol,
  output logic           illegal
);

  // Table lookup; unknown functs fall back to ADD and raise illegal.
  always_comb begin
    alucontrol = ALU_ADD;
    illegal    = 1'b0;
    case (funct)
      FNW'(FN_ADD): alucontrol = ALU_ADD;
      FNW'(FN_SUB): alucontrol = ALU_SUB;
      FNW'(FN_AND): alucontrol = ALU_AND;
      FNW'(FN_OR):  alucontrol = ALU_OR;
      FNW'(FN_SLT): alucontrol = ALU_SLT;
      default:      illegal    = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit for a shared instruction/data memory datapath.
//
// state  | meaning
// FETCH  | read instruction at PC, PC <- PC+1 when memory ready
// DECODE | dispatch on opcode, precompute branch target
// MEMADR | compute load/store address
// MEMRD  | data read, wait for memory ready
// MEMWB  | write loaded data to rt
// MEMWR  | data write, wait for memory ready
// EXEC   | R-type ALU operation
// ALUWB  | write ALU result to rd
// BRANCH | compare operands, take branch on zero
// ADDIEX | register + immediate
// ADDIWB | write ADDI result to rt
// JUMP   | load jump target into PC
// HALT   | illegal encoding seen, parked until reset
module mc_controller
  import mc_pkg::*;
#(
  parameter int OPW = 3,
  parameter int FNW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic [FNW-1:0] funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           memread,
  output logic           memwrite,
  output logic           iord,
  output logic           irwrite,
  output logic           pcwrite,
  output logic [1:0]     pcsrc,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [2:0]     alucontrol,
  output logic           regdst,
  output logic           memtoreg,
  output logic           regwrite,
  output logic           halted,
  output logic [3:0]     state
);

  state_t     state_q, state_d;
  logic [2:0] fn_alucontrol;
  logic       fn_illegal;

  mc_aludec #(.FNW(FNW)) u_aludec (
    .funct      (funct),
    .alucontrol (fn_alucontrol),
    .illegal    (fn_illegal)
  );

  // State register; reset always lands in FETCH.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; memory states hold until mem_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OPW'(OP_RTYPE): state_d = fn_illegal ? ST_HALT : ST_EXEC;
          OPW'(OP_LW):    state_d = ST_MEMADR;
          OPW'(OP_SW):    state_d = ST_MEMADR;
          OPW'(OP_BEQ):   state_d = ST_BRANCH;
          OPW'(OP_ADDI):  state_d = ST_ADDIEX;
          OPW'(OP_J):     state_d = ST_JUMP;
          default:        state_d = ST_HALT;
        endcase
      end
      ST_MEMADR: state_d = (opcode == OPW'(OP_LW)) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWB:  state_d = ST_FETCH;
      ST_MEMWR:  if (mem_ready) state_d = ST_FETCH;
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ALUWB:  state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_ADDIWB: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Output decode; FETCH and BRANCH writes follow mem_ready / zero directly,
  // and reset masks every enable so an aborted instruction writes nothing.
  always_comb begin
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    pcsrc      = PCSRC_ALU;
    alusrca    = 1'b0;
    alusrcb    = ALUB_REGB;
    alucontrol = ALU_ADD;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    halted     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        memread = 1'b1;
        alusrcb = ALUB_ONE;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      ST_DECODE: alusrcb = ALUB_BOFF;
      ST_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = ALUB_SEXT;
      end
      ST_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
      end
      ST_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      ST_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      ST_EXEC: begin
        alusrca    = 1'b1;
        alusrcb    = ALUB_REGB;
        alucontrol = fn_alucontrol;
      end
      ST_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      ST_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = PCSRC_ALUOUT;
        pcwrite    = zero;
      end
      ST_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUB_SEXT;
      end
      ST_ADDIWB: regwrite = 1'b1;
      ST_JUMP: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
    if (reset) begin
      memread  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      regwrite = 1'b0;
      halted   = 1'b0;
    end
  end

  assign state = state_q;

endmodule
